// File: rtl/mux_rr_feeder.sv
// Payload types for the parameterized multiplexer, plus the round-robin
// feeder that drives the mux select and registers its output into a
// single-entry valid/ready stage.

package MuxParam_pkg;

   typedef enum logic [2:0] {
      OpNop = 3'd0,
      OpAdd = 3'd1,
      OpSub = 3'd2,
      OpAnd = 3'd3,
      OpOr  = 3'd4,
      OpXor = 3'd5,
      OpLd  = 3'd6,
      OpSt  = 3'd7
   } op_codes_e_t;

   typedef struct packed {
      logic [7:0] addr;
      logic       we;
      logic [3:0] be;
      logic [7:0] wdata;
   } mem_ctl_st_t;

endpackage

module mux_rr_feeder #(
   parameter type         T   = MuxParam_pkg::op_codes_e_t,
   parameter int unsigned SEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2**SEL-1:0] Req,
   output logic [2**SEL-1:0] Ack,
   output logic [SEL-1:0]    Select,
   input  T                  MuxOut,
   output T                  OutData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [SEL-1:0]    LastGrant
);

   localparam int unsigned N = 2**SEL;

   logic           out_valid_q, out_valid_d;
   T               out_data_q, out_data_d;
   logic [SEL-1:0] last_grant_q, last_grant_d;

   logic           free;
   logic           grant;
   logic           cand_found;
   logic [SEL-1:0] cand_idx;
   logic [SEL-1:0] idx;

   // Round-robin search starting one past the last grant; the last granted
   // lane is visited last (offset N wraps back onto it).
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = last_grant_q;
      idx        = last_grant_q;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = last_grant_q + SEL'(i);
         if (!cand_found && Req[idx]) begin
            cand_found = 1'b1;
            cand_idx   = idx;
         end
      end
   end

   // Grant whenever the output register can take a payload; reset masks Ack.
   always_comb begin
      free   = !out_valid_q || OutReady;
      grant  = rst_n && free && cand_found;
      // cand_idx already falls back to last_grant_q when nothing requests.
      Select = cand_idx;
      Ack    = grant ? (N'(1) << cand_idx) : '0;
   end

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      last_grant_d = last_grant_q;
      if (grant) begin
         // Load wins over a simultaneous drain.
         out_valid_d  = 1'b1;
         out_data_d   = MuxOut;
         last_grant_d = cand_idx;
      end else if (out_valid_q && OutReady) begin
         out_valid_d  = 1'b0;
      end
   end

   // State registers; reset leaves lane 0 with first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= T'(0);
         last_grant_q <= '1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign OutValid  = out_valid_q;
   assign OutData   = out_data_q;
   assign LastGrant = last_grant_q;

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Scoreboard bench for mux_rr_feeder: enum payload under random traffic
// with a mid-run reset, plus a struct-payload instance for async reset
// during a stalled transfer.

module tb_mux_rr_feeder;
   import MuxParam_pkg::*;

   localparam int SEL = 2;
   localparam int N   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Enum-payload instance
   logic           rst_n;
   logic [N-1:0]   req, ack;
   logic [SEL-1:0] sel, last_grant;
   op_codes_e_t    mux_out, out_data;
   logic           out_valid, out_ready;
   op_codes_e_t    entry [N];

   assign mux_out = entry[sel];

   mux_rr_feeder #(.T(op_codes_e_t), .SEL(SEL)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Req      (req),
      .Ack      (ack),
      .Select   (sel),
      .MuxOut   (mux_out),
      .OutData  (out_data),
      .OutValid (out_valid),
      .OutReady (out_ready),
      .LastGrant(last_grant)
   );

   // Struct-payload instance
   logic           rst1_n;
   logic [N-1:0]   req1, ack1;
   logic [SEL-1:0] sel1, last_grant1;
   mem_ctl_st_t    mux_out1, out_data1;
   logic           out_valid1, out_ready1;
   mem_ctl_st_t    entry1 [N];

   assign mux_out1 = entry1[sel1];

   mux_rr_feeder #(.T(mem_ctl_st_t), .SEL(SEL)) u_dut_st (
      .clk      (clk),
      .rst_n    (rst1_n),
      .Req      (req1),
      .Ack      (ack1),
      .Select   (sel1),
      .MuxOut   (mux_out1),
      .OutData  (out_data1),
      .OutValid (out_valid1),
      .OutReady (out_ready1),
      .LastGrant(last_grant1)
   );

   // Reference model state
   int          lg_m;
   bit          v_m;
   op_codes_e_t q_exp [$];
   op_codes_e_t last_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // First requesting lane after lg, circularly; lg itself last.
   function automatic int rr_pick(input logic [N-1:0] r, input int lg);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (lg + k) % N;
         if (r[i]) return i;
      end
      return lg;
   endfunction

   task automatic model_reset();
      q_exp.delete();
      lg_m      = N - 1;
      v_m       = 1'b0;
      last_data = op_codes_e_t'(0);
   endtask

   // One cycle of stimulus: drive, check combinational outputs, update model.
   task automatic cycle(input logic [N-1:0] r, input bit rdy);
      int           c;
      bit           g;
      logic [N-1:0] exp_ack;
      @(negedge clk);
      #1;
      req       = r;
      out_ready = rdy;
      for (int i = 0; i < N; i++) entry[i] = op_codes_e_t'($urandom_range(0, 7));
      #1;
      chk("out_valid", 64'(out_valid), 64'(v_m));
      chk("last_grant", 64'(last_grant), 64'(lg_m));
      c       = rr_pick(r, lg_m);
      g       = (!v_m || rdy) && (r != '0);
      exp_ack = g ? (N'(1) << c) : '0;
      chk("select", 64'(sel), 64'((r != '0) ? c : lg_m));
      chk("ack", 64'(ack), 64'(exp_ack));
      if (g) begin
         q_exp.push_back(entry[c]);
         lg_m = c;
         v_m  = 1'b1;
      end else if (v_m && rdy) begin
         v_m = 1'b0;
      end
   endtask

   // Monitor: compare the presented payload against the scoreboard head,
   // popping it on handshake; when idle, OutData must hold its last value.
   always begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1) begin
         if (out_valid) begin
            if (q_exp.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=%0h required=none", out_data);
            end else begin
               chk("out_data", 64'(out_data), 64'(q_exp[0]));
               if (out_ready) begin
                  last_data = q_exp.pop_front();
               end
            end
         end else begin
            chk("held_data", 64'(out_data), 64'(last_data));
         end
      end
   end

   task automatic async_reset_dut0();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      req   = 4'b1111;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_last_grant", 64'(last_grant), 64'(N - 1));
      chk("rst_data", 64'(out_data), 64'd0);
      model_reset();
      @(negedge clk);
      #1;
      req   = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      mem_ctl_st_t e_st;
      rst_n     = 1'b0;
      rst1_n    = 1'b0;
      req       = '0;
      req1      = '0;
      out_ready = 1'b1;
      out_ready1 = 1'b1;
      for (int i = 0; i < N; i++) begin
         entry[i]  = op_codes_e_t'(i);
         entry1[i] = '0;
      end
      model_reset();

      // Reset state with all lanes requesting
      async_reset_dut0();

      // Full-load round robin
      for (int k = 0; k < 8; k++) cycle(4'b1111, 1'b1);
      // Sparse wrap: after lane 3 -> lanes 0,1,0 ... then back-pressure on lane 2
      cycle(4'b0100, 1'b1);
      for (int k = 0; k < 3; k++) cycle(4'b0011, 1'b1);
      for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b1);
      // Idle drain after a single lane-3 pulse
      cycle(4'b0000, 1'b1);
      cycle(4'b1000, 1'b1);
      for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

      // Random traffic with a reset in the middle
      for (int k = 0; k < 400; k++) begin
         if (k == 200) async_reset_dut0();
         cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
      end
      for (int k = 0; k < 4; k++) cycle(4'b0000, 1'b1);
      chk("queue_empty", 64'(q_exp.size()), 64'd0);

      // Struct payload: load lane 2, stall, then async reset without an edge
      for (int i = 0; i < N; i++) begin
         entry1[i].addr  = 8'(8'h10 + i);
         entry1[i].we    = i[0];
         entry1[i].be    = 4'(4'h1 << i);
         entry1[i].wdata = 8'(8'hA0 + i);
      end
      #1;
      chk("st_rst_valid", 64'(out_valid1), 64'd0);
      chk("st_rst_data", 64'(out_data1), 64'd0);
      @(negedge clk);
      #1;
      rst1_n = 1'b1;
      @(negedge clk);
      #1;
      req1       = 4'b0100;
      out_ready1 = 1'b1;
      e_st       = entry1[2];
      #1;
      chk("st_ack", 64'(ack1), 64'(4'b0100));
      @(negedge clk);
      #1;
      out_ready1 = 1'b0;
      for (int i = 0; i < N; i++) entry1[i].wdata = 8'(8'h50 + i);
      #1;
      chk("st_valid", 64'(out_valid1), 64'd1);
      chk("st_data", 64'(out_data1), 64'(e_st));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("st_stall_ack", 64'(ack1), 64'd0);
         chk("st_stall_data", 64'(out_data1), 64'(e_st));
      end
      @(posedge clk);
      #2;
      rst1_n = 1'b0;
      #1;
      chk("st_async_valid", 64'(out_valid1), 64'd0);
      chk("st_async_data", 64'(out_data1), 64'd0);
      chk("st_async_ack", 64'(ack1), 64'd0);
      chk("st_async_last_grant", 64'(last_grant1), 64'(N - 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_rr_feeder.md
# mux_rr_feeder

Round-robin arbitration front-end that drives the `Select` input of the parameterized multiplexer and registers the multiplexer output into a valid/ready output stage. Up to `2**SEL` producers raise per-lane requests. The block picks one lane per cycle in round-robin order and acknowledges it. It then captures the multiplexed payload (enum or struct type from `MuxParam_pkg`) into a single-entry output register for the downstream consumer.

## Interface
Parameters:
- `T`, default `MuxParam_pkg::op_codes_e_t`: payload type carried through the multiplexer.
- `SEL`, default 2: select width. Lane count `N = 2**SEL`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `Req`  in  N  per-lane request. Lane i's payload is valid on the mux `Entry[i]` while `Req[i]`=1.
- `Ack`  out  N  one-hot. `Ack[i]`=1 in the cycle lane i's payload is captured. The producer retires or advances its entry on the next edge.
- `Select`  out  SEL  to the mux `Select` input.
- `MuxOut`  in  type T  from the mux `Sal` output.
- `OutData`  out  type T  registered payload.
- `OutValid`  out  1  `OutData` holds an unconsumed payload.
- `OutReady`  in  1  downstream accepts `OutData` in this cycle when `OutValid`=1.
- `LastGrant`  out  SEL  registered index of the most recently acknowledged lane.

## Operation
- State: output register (`OutValid`, `OutData`) and round-robin pointer `LastGrant`. There is no other FSM.
- `Free` = !`OutValid` | `OutReady`. The register can load this cycle.
- Candidate lane = the first i with `Req[i]`=1, searching `LastGrant`+1, `LastGrant`+2, … mod N. `LastGrant` itself is searched last.
- Grant condition: `Free` & |`Req`.
- `Select` (combinational):
  - candidate index when the grant condition holds;
  - otherwise candidate index if any `Req` is set;
  - otherwise `LastGrant`.
- `Ack` (combinational): one-hot of the candidate when the grant condition holds, else 0. `Ack` never depends on `OutData`.
- On the clock edge when the grant condition holds:
  - `OutData` <= `MuxOut`;
  - `OutValid` <= 1;
  - `LastGrant` <= candidate.
- On the clock edge with `OutValid` & `OutReady` & no grant: `OutValid` <= 0. `OutData` holds its last value.
- When `OutValid` & !`OutReady`: `OutData`, `OutValid` and `LastGrant` hold, and `Ack`=0. `OutData` must not change while stalled.
- Drain and load in the same cycle: the load takes priority. `OutValid` stays 1 with the new payload.
- A request that drops without an `Ack` is simply not served. There is no obligation on producers.
- `T` is used only for storage and pass-through. No arithmetic is performed on the payload. The pointer wraps N-1 -> 0 by natural SEL-bit overflow.

## Timing
- Reset (async assert, any time, including mid-transfer):
  - `OutValid`=0;
  - `OutData`=`T'(0)`;
  - `LastGrant`=N-1, so lane 0 has first priority after reset;
  - `Ack`=0 while `rst_n`=0;
  - any pending payload is discarded.
- Reset deassertion is synchronous to `clk` at the integration level. The first grant can occur in the first cycle after deassertion.
- Latency:
  - `Req[i]` high in cycle n with `Free` -> `Ack[i]`=1 in cycle n;
  - `OutValid`=1 and `OutData`=`Entry[i]` (as seen in cycle n) in cycle n+1.
- Throughput: one payload per cycle while `OutReady`=1 and at least one `Req` is set.
- Fairness: with all N lanes requesting continuously and `OutReady`=1, each lane is acknowledged exactly once in every N consecutive grants.
- `MuxOut` must settle within the same cycle as `Select`. This is a combinational path `Req` -> `Select` -> mux -> `MuxOut` -> `OutData` D-input.

## Test plan
- Reset value check: assert `rst_n`=0 with `Req`=4'b1111 -> `OutValid`=0, `Ack`=0, `LastGrant`=3, `OutData`=0. Release reset -> `Ack`=4'b0001 in the first cycle and `OutData`=`Entry[0]` on the next cycle.
- Full-load round robin: SEL=2, `Req`=4'b1111 held, `OutReady`=1 for 8 cycles -> `Ack` sequence 0001, 0010, 0100, 1000, 0001, …; `OutData` follows `Entry[0..3]` one cycle later.
- Sparse wrap-around: `LastGrant`=2, `Req`=4'b0011 -> grant lane 0 (wrap), then lane 1, then lane 0. `Select`=0,1,0.
- Back-pressure: `OutValid`=1 and `OutReady`=0 for 3 cycles with `Req`=4'b0100 -> `Ack`=0 and `OutData` stable. Raise `OutReady` -> `Ack`=4'b0100 in that cycle and the new payload appears next cycle with `OutValid` staying 1.
- Idle drain: single `Req[3]` pulse then `Req`=0, `OutReady`=1 -> `OutValid` is 1 for exactly one cycle, then 0, and `OutData` retains `Entry[3]`.
- Struct payload: instantiate with `T`=`MuxParam_pkg::mem_ctl_st_t` and distinct field values per lane. Assert async reset during a stalled transfer -> `OutValid`=0 immediately (no clock edge) and `OutData`=all-zero struct.
